// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_ADDR_W = 20;
    localparam int unsigned DMEM_DATA_W = 32;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, owner} alongside each in-flight read.
module rd_tag_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic    clk,
    input  logic    rstn,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t [LAT-1:0] stage_q;
    rd_tag_t [LAT-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_i;
        for (int i = 1; i < int'(LAT); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Synchronous clear drops every read still in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o = stage_q[LAT-1];

endmodule : rd_tag_pipe

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: A has priority, B is aged to avoid starvation.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DMEM_ADDR_W,
    parameter int unsigned DATA_W   = DMEM_DATA_W,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             force_b;
    rd_tag_t          tag_in;
    rd_tag_t          tag_out;

    assign force_b = b_req && (wait_cnt_q >= CNT_W'(MAX_WAIT));

    // Grant selection and memory mux; everything is held quiet while in reset.
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (rstn) begin
            if (force_b) begin
                b_gnt = 1'b1;
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
        if (a_gnt) begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_we    = a_we;
        end else if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_we    = b_we;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!b_req || b_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < CNT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (a_gnt && !a_we) || (b_gnt && !b_we);
        tag_in.owner = b_gnt ? OWNER_B : OWNER_A;
    end

    rd_tag_pipe #(
        .LAT (READ_LAT)
    ) u_rd_tag_pipe (
        .clk   (clk),
        .rstn  (rstn),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign a_rvalid = rstn && tag_out.valid && (tag_out.owner == OWNER_A);
    assign b_rvalid = rstn && tag_out.valid && (tag_out.owner == OWNER_B);
    assign a_rdata  = mem_rdata;
    assign b_rdata  = mem_rdata;

endmodule : dmem_arbiter
